// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared types, constants and helpers for the interrupt scheduler
package irq_pkg;

    localparam int NUM_IRQ = 7;
    localparam int VEC_W   = 3;
    localparam logic [VEC_W-1:0]   VEC_NONE = '0;
    localparam logic [NUM_IRQ-1:0] MASK_RST = 7'h7F;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

    // Vector numbers are 1-based; vector 0 maps to an all-zero mask.
    function automatic logic [NUM_IRQ-1:0] vec_onehot(input logic [VEC_W-1:0] vec);
        logic [NUM_IRQ-1:0] oh;
        oh = '0;
        for (int i = 1; i <= NUM_IRQ; i++) begin
            if (vec == VEC_W'(i)) oh[i-1] = 1'b1;
        end
        return oh;
    endfunction

    function automatic logic [VEC_W-1:0] next_vec(input logic [VEC_W-1:0] vec);
        return (vec >= VEC_W'(NUM_IRQ)) ? VEC_W'(1) : vec + VEC_W'(1);
    endfunction

endpackage

// File: rtl/irq_prio_sel.sv
// rtl/irq_prio_sel.sv - combinational circular priority search from a start vector
module irq_prio_sel
    import irq_pkg::*;
(
    input  logic [NUM_IRQ-1:0] eligible,
    input  logic [VEC_W-1:0]   start,
    output logic [VEC_W-1:0]   vector,
    output logic               valid
);

    always_comb begin
        logic [2:0] w_base;
        logic [2:0] w_idx;
        vector = VEC_NONE;
        valid  = 1'b0;
        w_base = (start == VEC_NONE) ? 3'd0 : start - 3'd1;
        w_idx  = 3'd0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            w_idx = 3'((int'(w_base) + k) % NUM_IRQ);
            if (!valid && eligible[w_idx]) begin
                valid  = 1'b1;
                vector = w_idx + 3'd1;
            end
        end
    end

endmodule

// File: rtl/irq_sched.sv
// rtl/irq_sched.sv - edge-triggered 7-vector interrupt scheduler (IDLE/REQ/SERVICE)
// Optional IRQ_ROUND_ROBIN_EN: rotating priority starting after the last acknowledged vector.
module irq_sched
    import irq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    input  logic               irq_ack,
    input  logic               eoi,
    output logic               irq_req,
    output logic [VEC_W-1:0]   irq_vec,
    output logic               busy,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] mask
);

    irq_state_e         r_state;
    logic [NUM_IRQ-1:0] r_irq_d;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_mask;
    logic               r_req;
    logic               r_busy;
    logic [VEC_W-1:0]   r_vec;

    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_clr;
    logic [NUM_IRQ-1:0] w_eligible;
    logic [VEC_W-1:0]   w_start;
    logic [VEC_W-1:0]   w_sel;
    logic               w_sel_valid;
    logic               w_ack;

    assign w_rise     = irq_in & ~r_irq_d;
    assign w_eligible = r_pending & r_mask;
    assign w_ack      = (r_state == REQ) && irq_ack;
    assign w_clr      = w_ack ? vec_onehot(r_vec) : '0;

`ifdef IRQ_ROUND_ROBIN_EN
    logic [VEC_W-1:0] r_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last <= VEC_W'(NUM_IRQ);
        end else if (w_ack) begin
            r_last <= r_vec;
        end
    end

    assign w_start = next_vec(r_last);
`else
    assign w_start = VEC_W'(1);
`endif

    irq_prio_sel u_prio_sel (
        .eligible (w_eligible),
        .start    (w_start),
        .vector   (w_sel),
        .valid    (w_sel_valid)
    );

    // Clearing on ack and setting on a fresh edge share one update so a
    // coincident edge on the acknowledged vector re-pends it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_irq_d   <= '0;
            r_pending <= '0;
            r_mask    <= MASK_RST;
            r_req     <= 1'b0;
            r_busy    <= 1'b0;
            r_vec     <= VEC_NONE;
        end else begin
            r_irq_d   <= irq_in;
            r_pending <= (r_pending & ~w_clr) | w_rise;
            if (mask_we) r_mask <= mask_wdata;
            case (r_state)
                IDLE: begin
                    if (w_sel_valid) begin
                        r_vec   <= w_sel;
                        r_req   <= 1'b1;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (irq_ack) begin
                        r_req   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (eoi) begin
                        r_busy  <= 1'b0;
                        r_vec   <= VEC_NONE;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_vec   <= VEC_NONE;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign irq_req = r_req;
    assign irq_vec = r_vec;
    assign busy    = r_busy;
    assign pending = r_pending;
    assign mask    = r_mask;

endmodule

// File: tb/tb_irq_sched.sv
// tb/tb_irq_sched.sv - directed and randomized checks of irq_sched against a behavioural model
module tb_irq_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] irq_in = '0;
    logic       mask_we = 1'b0;
    logic [6:0] mask_wdata = '0;
    logic       irq_ack = 1'b0;
    logic       eoi = 1'b0;
    logic       irq_req;
    logic [2:0] irq_vec;
    logic       busy;
    logic [6:0] pending;
    logic [6:0] mask;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef IRQ_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    // Behavioural model: phase 0 = idle, 1 = presenting, 2 = in service.
    bit         m_pend [7];
    bit         m_prev [7];
    logic [6:0] m_mask;
    int         m_phase;
    int         m_vec;
    int         m_last;

    irq_sched dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .irq_ack    (irq_ack),
        .eoi        (eoi),
        .irq_req    (irq_req),
        .irq_vec    (irq_vec),
        .busy       (busy),
        .pending    (pending),
        .mask       (mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] m_pend_vec();
        logic [6:0] v;
        for (int i = 0; i < 7; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 7; i++) begin
            m_pend[i] = 1'b0;
            m_prev[i] = 1'b0;
        end
        m_mask  = 7'h7F;
        m_phase = 0;
        m_vec   = 0;
        m_last  = 7;
    endtask

    task automatic model_step();
        int  sel;
        int  first;
        int  v;
        bit  np [7];
        bit  rise;
        bit  clr;
        sel   = 0;
        first = RR ? ((m_last == 7) ? 1 : m_last + 1) : 1;
        for (int k = 0; k < 7; k++) begin
            v = ((first - 1 + k) % 7) + 1;
            if (sel == 0 && m_pend[v-1] && m_mask[v-1]) sel = v;
        end
        for (int i = 0; i < 7; i++) begin
            rise  = irq_in[i] && !m_prev[i];
            clr   = (m_phase == 1) && irq_ack && (m_vec == i + 1);
            np[i] = (m_pend[i] && !clr) || rise;
        end
        case (m_phase)
            0: if (sel != 0) begin m_phase = 1; m_vec = sel; end
            1: if (irq_ack) begin m_phase = 2; m_last = m_vec; end
            default: if (eoi) begin m_phase = 0; m_vec = 0; end
        endcase
        if (mask_we) m_mask = mask_wdata;
        for (int i = 0; i < 7; i++) begin
            m_pend[i] = np[i];
            m_prev[i] = irq_in[i];
        end
    endtask

    task automatic compare_model();
        check("model_irq_req", 32'(irq_req), 32'(m_phase == 1));
        check("model_irq_vec", 32'(irq_vec), 32'(m_vec));
        check("model_busy",    32'(busy),    32'(m_phase == 2));
        check("model_pending", 32'(pending), 32'(m_pend_vec()));
        check("model_mask",    32'(mask),    32'(m_mask));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_step();
        compare_model();
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b0;
        #1;
        check("rst_irq_req", 32'(irq_req), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_irq_vec", 32'(irq_vec), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        check("rst_mask", 32'(mask), 32'h7F);
        rst = 1'b1;
    endtask

    initial begin
        int got [4];
        int exp38 [4];
        model_reset();
        async_reset();

        // Single vector 3: pend, present, ack, eoi
        irq_in = 7'h04;
        step();
        check("t34_pend_e0", 32'(pending), 32'h04);
        check("t34_noreq_e0", 32'(irq_req), 32'd0);
        step();
        check("t34_req_e1", 32'(irq_req), 32'd1);
        check("t34_vec_e1", 32'(irq_vec), 32'd3);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("t34_ack_pend", 32'(pending), 32'h00);
        check("t34_ack_busy", 32'(busy), 32'd1);
        check("t34_ack_req", 32'(irq_req), 32'd0);
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        check("t34_eoi_busy", 32'(busy), 32'd0);
        check("t34_eoi_vec", 32'(irq_vec), 32'd0);
        irq_in = 7'h00;

        // Vectors 5 and 2 together: 2 first, then 5
        irq_in = 7'h12;
        step();
        check("t35_pend", 32'(pending), 32'h12);
        step();
        check("t35_first", 32'(irq_vec), 32'd2);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        step();
        check("t35_second_req", 32'(irq_req), 32'd1);
        check("t35_second", 32'(irq_vec), 32'd5);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        irq_in = 7'h00;

        // Masked vector 1 stays pending until re-enabled
        mask_we = 1'b1;
        mask_wdata = 7'h7E;
        step();
        mask_we = 1'b0;
        check("t36_mask", 32'(mask), 32'h7E);
        irq_in = 7'h01;
        step();
        check("t36_pend", 32'(pending[0]), 32'd1);
        step();
        check("t36_noreq", 32'(irq_req), 32'd0);
        mask_we = 1'b1;
        mask_wdata = 7'h7F;
        step();
        mask_we = 1'b0;
        check("t36_noreq_we", 32'(irq_req), 32'd0);
        step();
        check("t36_req", 32'(irq_req), 32'd1);
        check("t36_vec", 32'(irq_vec), 32'd1);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        irq_in = 7'h00;

        // No preemption of vector 4 by vector 1
        irq_in = 7'h08;
        step();
        step();
        check("t37_vec4", 32'(irq_vec), 32'd4);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        irq_in = 7'h09;
        step();
        check("t37_pend1", 32'(pending[0]), 32'd1);
        step();
        check("t37_noreq", 32'(irq_req), 32'd0);
        check("t37_svc_vec", 32'(irq_vec), 32'd4);
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        step();
        check("t37_req1", 32'(irq_req), 32'd1);
        check("t37_vec1", 32'(irq_vec), 32'd1);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        irq_in = 7'h00;

        // Vectors 1 and 3 re-pended each round, from a fresh pointer
        async_reset();
        if (RR) begin
            exp38[0] = 1; exp38[1] = 3; exp38[2] = 1; exp38[3] = 3;
        end else begin
            exp38[0] = 1; exp38[1] = 1; exp38[2] = 1; exp38[3] = 1;
        end
        irq_in = 7'h05;
        step();
        step();
        for (int r = 0; r < 4; r++) begin
            got[r] = int'(irq_vec);
            check($sformatf("t38_vec%0d", r), 32'(got[r]), 32'(exp38[r]));
            irq_ack = 1'b1;
            step();
            irq_ack = 1'b0;
            irq_in = 7'h00;
            step();
            irq_in = 7'h05;
            step();
            eoi = 1'b1;
            step();
            eoi = 1'b0;
            step();
        end
        irq_in = 7'h00;
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        eoi = 1'b1;
        step();
        eoi = 1'b0;

        // Asynchronous reset while presenting vector 2
        mask_we = 1'b1;
        mask_wdata = 7'h3F;
        step();
        mask_we = 1'b0;
        while (irq_req || busy || pending != 7'h00) begin
            irq_ack = irq_req;
            eoi = busy;
            step();
        end
        irq_ack = 1'b0;
        eoi = 1'b0;
        irq_in = 7'h02;
        step();
        step();
        check("t39_req", 32'(irq_req), 32'd1);
        check("t39_vec", 32'(irq_vec), 32'd2);
        async_reset();
        irq_in = 7'h00;
        step();

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            irq_in     = irq_in ^ (7'($urandom) & 7'($urandom) & 7'($urandom));
            mask_we    = ($urandom_range(0, 15) == 0);
            mask_wdata = 7'($urandom);
            irq_ack    = 1'($urandom_range(0, 1));
            eoi        = ($urandom_range(0, 2) == 0);
            if (c == 300) async_reset();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
